// File: rtl/pll_lock_ce_seq.sv
// rtl/pll_lock_ce_seq.sv - PLL lock qualifier, core reset sequencer and 12/6/3 MHz clock-enable generator
// Optional lock-loss counter built only when PLL_LOCK_LOSS_CNT_EN is defined.
module pll_lock_ce_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       core_reset_n,
  output logic       ce_12,
  output logic       ce_6,
  output logic       ce_6b,
  output logic       ce_3,
  output logic       lock_ok,
  output logic       lock_lost,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                     : RESET_HOLD_CYCLES;
  localparam int CW = $clog2(MAX_CYC);

  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_STABLE    = 2'd1;
  localparam logic [1:0] S_RELEASE   = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic          sync1;
  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    div, div_nx;
  logic          lost_nx;
  logic          run_now, run_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lost_nx  = 1'b0;
    case (state)
      S_WAIT_LOCK: begin
        cnt_nx = '0;
        if (lock_ok) state_nx = S_STABLE;
      end
      S_STABLE: begin
        if (!lock_ok) begin
          state_nx = S_WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nx = S_RELEASE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_RELEASE: begin
        if (!lock_ok) begin
          state_nx = S_WAIT_LOCK;
          cnt_nx   = '0;
          lost_nx  = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_RUN: begin
        cnt_nx = '0;
        if (!lock_ok) begin
          state_nx = S_WAIT_LOCK;
          lost_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = S_WAIT_LOCK;
        cnt_nx   = '0;
      end
    endcase
  end

  // The divider starts at 0 on the first RELEASE cycle, so enables are decoded
  // from the next-cycle divider value to land on that very cycle.
  assign run_now = (state == S_RELEASE) || (state == S_RUN);
  assign run_nx  = (state_nx == S_RELEASE) || (state_nx == S_RUN);

  always_comb begin
    div_nx = 4'd0;
    if (run_nx && run_now) div_nx = (div == 4'd11) ? 4'd0 : div + 4'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync1        <= 1'b0;
      lock_ok      <= 1'b0;
      state        <= S_WAIT_LOCK;
      cnt          <= '0;
      div          <= 4'd0;
      core_reset_n <= 1'b0;
      ce_12        <= 1'b0;
      ce_6         <= 1'b0;
      ce_6b        <= 1'b0;
      ce_3         <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      sync1        <= pll_locked;
      lock_ok      <= sync1;
      state        <= state_nx;
      cnt          <= cnt_nx;
      div          <= div_nx;
      core_reset_n <= (state_nx == S_RUN);
      ce_12        <= run_nx && ((div_nx == 4'd0) || (div_nx == 4'd3) ||
                                 (div_nx == 4'd6) || (div_nx == 4'd9));
      ce_6         <= run_nx && ((div_nx == 4'd0) || (div_nx == 4'd6));
      ce_6b        <= run_nx && ((div_nx == 4'd3) || (div_nx == 4'd9));
      ce_3         <= run_nx && (div_nx == 4'd0);
      lock_lost    <= lost_nx;
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      loss_cnt_q <= 8'd0;
    end else if (lost_nx && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: doc/pll_lock_ce_seq.md
PLL_LOCK_CE_SEQ -- requirements
Module: pll_lock_ce_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024; the number of consecutive synchronized-lock cycles required before reset sequencing starts; legal minimum 2.
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 16; the number of cycles core_reset_n is held low with clock enables running; legal minimum 1.
REQ-003 clk_sys  input  1  sole clock, the 36 MHz PLL output; all logic is on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 pll_locked  input  1  PLL lock flag; asynchronous to clk_sys.
REQ-006 core_reset_n  output  1  active-low reset to the downstream core.
REQ-007 ce_12  output  1  single-cycle 12 MHz clock enable.
REQ-008 ce_6  output  1  single-cycle 6 MHz clock enable.
REQ-009 ce_6b  output  1  6 MHz clock enable, offset 180 degrees from ce_6.
REQ-010 ce_3  output  1  single-cycle 3 MHz clock enable.
REQ-011 lock_ok  output  1  synchronized lock flag.
REQ-012 lock_lost  output  1  one-cycle pulse on each loss of lock while in RUN or RELEASE.
REQ-013 lock_loss_cnt  output  8  count of lock_lost pulses.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer; lock_ok equals the second flop, giving 2-cycle latency.
REQ-015 The FSM SHALL have the states WAIT_LOCK, STABLE, RELEASE and RUN.
REQ-016 WAIT_LOCK: stability counter = 0; on lock_ok=1 go to STABLE.
REQ-017 STABLE: the counter increments each cycle with lock_ok=1; lock_ok=0 clears it and returns to WAIT_LOCK; count = LOCK_STABLE_CYCLES-1 goes to RELEASE and clears the counter.
REQ-018 RELEASE: the counter increments each cycle; count = RESET_HOLD_CYCLES-1 goes to RUN.
REQ-019 RUN: core_reset_n=1, registered, and asserted high on the first RUN cycle.
REQ-020 lock_ok=0 in RELEASE or RUN SHALL go to WAIT_LOCK next cycle and pulse lock_lost for that cycle.
REQ-021 In WAIT_LOCK, STABLE and RELEASE, core_reset_n SHALL be 0.
REQ-022 The divider SHALL count 0..11 and wrap to 0; it advances only in RELEASE and RUN and is held at 0 otherwise.
REQ-023 Clock enables SHALL be registered and decoded from the divider: ce_12 at div in {0,3,6,9}; ce_6 at {0,6}; ce_6b at {3,9}; ce_3 at {0}.
REQ-024 All clock enables SHALL be 0 in WAIT_LOCK and STABLE.
REQ-025 Lock loss SHALL force all clock enables to 0 from the cycle after lock_ok falls.
REQ-026 The stability counter width SHALL be clog2 of max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES).
REQ-027 lock_loss_cnt SHALL saturate at 255 and never wrap.
REQ-028 When lock_lost and reset_n=0 coincide, reset SHALL win.

Reset
REQ-029 With reset_n=0 at a clk_sys edge, the block SHALL enter WAIT_LOCK with the following state:
- synchronizer flops, counters and divider = 0
- core_reset_n = 0
- all clock enables = 0
- lock_ok = 0, lock_lost = 0, lock_loss_cnt = 0
REQ-030 Reset asserted mid-sequence, in any state, SHALL abort the sequence identically.

Configuration
REQ-031 Macro PLL_LOCK_LOSS_CNT_EN: when defined, lock_loss_cnt is implemented per REQ-027.
REQ-032 When the macro is undefined, lock_loss_cnt SHALL be tied to 0, the counter SHALL not be built, and lock_lost SHALL still pulse.

Verification (LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4)
REQ-033 Release reset with pll_locked=1 constantly -> lock_ok high 2 cycles later; STABLE for 8 cycles; core_reset_n low for 4 RELEASE cycles then high; ce_12 pulses every 3 cycles from the first RELEASE cycle.
REQ-034 Toggle pll_locked low for 1 cycle at STABLE count 5 -> return to WAIT_LOCK, counter restarts, no clock enable pulses.
REQ-035 In RUN, check 24 cycles -> ce_12 ×8, ce_6 ×4, ce_6b ×4 each 3 cycles after ce_6, ce_3 ×2, never two ce_6-family pulses together.
REQ-036 Drop pll_locked in RUN -> lock_lost single pulse, core_reset_n=0 and enables 0 the following cycle, lock_loss_cnt=1, full resequence on relock.
REQ-037 Perform 260 lock losses with the macro defined -> lock_loss_cnt=255; without the macro -> lock_loss_cnt=0.
REQ-038 Assert reset_n=0 during RELEASE -> all outputs at reset values the next cycle.
